// File: rtl/pll_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop-chain synchroniser for a single asynchronous level input.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up/recovery sequencer on the reference clock.
// Optional statistics counters are built only when PLL_SUPERVISOR_STATS_EN is defined.
//
// state      | meaning
// RESET_PLL  | pll_rst held high for RST_CYCLES, system held in reset
// WAIT_LOCK  | pll_rst released, waiting for synced lock or timeout
// STABLE     | lock seen, counting consecutive locked cycles
// RUN        | system reset released, watching for lock loss
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int TMR_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [1:0] S_RESET_PLL = RESET_PLL;
  localparam logic [1:0] S_WAIT_LOCK = WAIT_LOCK;
  localparam logic [1:0] S_STABLE    = STABLE;
  localparam logic [1:0] S_RUN       = RUN;

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

  logic             locked_s;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Lock wins over a coincident timeout in WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET_PLL: if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s)                    state_d = S_STABLE;
        else if (timer_q == LOCK_LAST)   state_d = S_RESET_PLL;
      end
      S_STABLE: begin
        if (!locked_s)                   state_d = S_WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN:       if (!locked_s) state_d = S_RESET_PLL;
      default:     state_d = S_RESET_PLL;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      timer_q     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= (state_d != state_q) ? '0 : timer_q + TMR_W'(state_q != S_RUN);
      pll_rst     <= (state_d == S_RESET_PLL);
      sys_reset_n <= (state_d == S_RUN);
    end
  end

  assign state_o = state_q;

`ifdef PLL_SUPERVISOR_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic retry_evt, loss_evt;

  assign retry_evt = (state_q == S_WAIT_LOCK) && !locked_s && (timer_q == LOCK_LAST);
  assign loss_evt  = (state_q == S_RUN) && !locked_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (retry_evt) retry_cnt <= CNT_W'(sat_inc(32'(retry_cnt), CNT_MAX));
      if (loss_evt)  loss_cnt  <= CNT_W'(sat_inc(32'(loss_cnt), CNT_MAX));
    end
  end
`else
  assign retry_cnt = '0;
  assign loss_cnt  = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: timestamp-based reference model plus directed scenario checks.
module tb_pll_lock_supervisor;

  localparam int RST_C  = 4;
  localparam int LOCK_T = 100;
  localparam int STAB_C = 16;
  localparam int SYNC_N = 2;
  localparam int CNT_W  = 8;
  localparam int CMAX   = 255;
`ifdef PLL_SUPERVISOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic pll_rst, sys_reset_n;
  logic [1:0] state_o;
  logic [CNT_W-1:0] retry_cnt, loss_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_T), .STABLE_CYCLES(STAB_C),
    .SYNC_STAGES(SYNC_N), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n), .state_o(state_o), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       prst;
    logic       srn;
    logic [7:0] rc;
    logic [7:0] lc;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: each mode remembers the edge it was entered on; exits are elapsed-time rules.
  int   cyc = 0;
  int   t0 = 0;
  int   m_mode = 0;
  int   m_ret = 0;
  int   m_loss = 0;
  logic lk_q[$];

  always @(posedge clk) begin
    logic ls;
    int   el;
    obs_t e;
    cyc++;
    if (!rst_n) begin
      m_mode = 0; t0 = cyc; m_ret = 0; m_loss = 0;
      lk_q.delete();
      for (int i = 0; i < SYNC_N; i++) lk_q.push_back(1'b0);
    end else begin
      ls = lk_q.pop_front();
      lk_q.push_back(pll_locked);
      el = cyc - t0;
      case (m_mode)
        0: if (el == RST_C) begin m_mode = 1; t0 = cyc; end
        1: begin
          if (ls) begin m_mode = 2; t0 = cyc; end
          else if (el == LOCK_T) begin
            m_mode = 0; t0 = cyc;
            if (m_ret < CMAX) m_ret++;
          end
        end
        2: begin
          if (!ls) begin m_mode = 1; t0 = cyc; end
          else if (el == STAB_C) begin m_mode = 3; t0 = cyc; end
        end
        default: if (!ls) begin
          m_mode = 0; t0 = cyc;
          if (m_loss < CMAX) m_loss++;
        end
      endcase
    end
    e.st   = 2'(m_mode);
    e.prst = (m_mode == 0);
    e.srn  = (m_mode == 3);
    e.rc   = STATS ? 8'(m_ret) : 8'd0;
    e.lc   = STATS ? 8'(m_loss) : 8'd0;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_o, pll_rst, sys_reset_n, retry_cnt, loss_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d got st=%0d prst=%0b srn=%0b rc=%0d lc=%0d expected st=%0d prst=%0b srn=%0b rc=%0d lc=%0d",
                 cyc, a.st, a.prst, a.srn, a.rc, a.lc, e.st, e.prst, e.srn, e.rc, e.lc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // sel 0 = pll_rst, 1 = sys_reset_n; returns edges taken to reach val.
  task automatic edges_until(input int sel, input logic val, input int budget, output int n);
    logic cur;
    n = 0;
    do begin
      tick(1);
      n++;
      cur = (sel == 0) ? pll_rst : sys_reset_n;
    end while (cur !== val && n < budget);
  endtask

  task automatic wait_state(input int s, input int budget, input string nm, output int n);
    n = 0;
    while (state_o !== 2'(s) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (state_o !== 2'(s)) begin
      errors++;
      $display("FAIL %s: state_o got %0d expected %0d after %0d cycles", nm, state_o, s, n);
    end
  endtask

  initial begin
    int n;
    int r0;

    // Bring-up with lock arriving 10 cycles after pll_rst release.
    tick(3);
    chk("reset_prst", pll_rst, 1);
    chk("reset_srn", sys_reset_n, 0);
    chk("reset_state", state_o, 0);
    rst_n = 1'b1;
    edges_until(0, 1'b0, 20, n);
    chk("bringup_prst_width", n, RST_C);
    tick(9);
    pll_locked = 1'b1;
    edges_until(1, 1'b1, 60, n);
    chk("bringup_lock_latency", n, SYNC_N + STAB_C + 1);
    chk("bringup_state", state_o, 3);
    chk("bringup_retry", retry_cnt, 0);
    chk("bringup_loss", loss_cnt, 0);

    // Lock loss in RUN and relock.
    pll_locked = 1'b0;
    edges_until(1, 1'b0, 10, n);
    chk("loss_latency", n, SYNC_N + 1);
    chk("loss_prst", pll_rst, 1);
    chk("loss_state", state_o, 0);
    chk("loss_cnt", loss_cnt, STATS ? 1 : 0);
    tick(2);
    pll_locked = 1'b1;
    wait_state(3, 100, "relock_run", n);

    // Single-cycle glitch during STABLE restarts the wait without a retry.
    r0 = retry_cnt;
    pll_locked = 1'b0;
    wait_state(1, 50, "glitch_wait_entry", n);
    pll_locked = 1'b1;
    wait_state(2, 10, "glitch_stable_entry", n);
    tick(10);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_state(1, 6, "glitch_back_to_wait", n);
    chk("glitch_srn", sys_reset_n, 0);
    wait_state(2, 10, "glitch_restable", n);
    wait_state(3, 40, "glitch_run", n);
    chk("glitch_stable_len", n, STAB_C);
    chk("glitch_retry", retry_cnt, r0);

    // rst_n asserted while running.
    rst_n = 1'b0;
    tick(1);
    chk("midrst_prst", pll_rst, 1);
    chk("midrst_srn", sys_reset_n, 0);
    chk("midrst_retry", retry_cnt, 0);
    chk("midrst_loss", loss_cnt, 0);

    // No lock: periodic retries.
    pll_locked = 1'b0;
    tick(1);
    rst_n = 1'b1;
    edges_until(0, 1'b0, 20, n);
    chk("retry_first_high", n, RST_C);
    for (int i = 0; i < 3; i++) begin
      edges_until(0, 1'b1, 200, n);
      chk("retry_low_len", n, LOCK_T);
      edges_until(0, 1'b0, 20, n);
      chk("retry_high_len", n, RST_C);
    end
    chk("retry_cnt3", retry_cnt, STATS ? 3 : 0);
    chk("retry_srn", sys_reset_n, 0);

    // Saturation of the loss counter.
    pll_locked = 1'b1;
    wait_state(3, 200, "sat_first_run", n);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_state(3, 100, "sat_run", n);
    end
    chk("loss_saturated", loss_cnt, STATS ? CMAX : 0);

    // Randomized lock activity with occasional resets, checked by the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      pll_locked = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 150));
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
